// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch slice: word width, PC step, NOP encoding
// and the next-PC select codes. The optional FETCH_MISALIGN_TRAP_EN build uses is_misaligned().
package mips_pkg;

    localparam int          WORD_W    = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef enum logic [2:0] {
        SEL_SEQ    = 3'd0,
        SEL_HOLD   = 3'd1,
        SEL_BRANCH = 3'd2,
        SEL_JUMP   = 3'd3,
        SEL_WRAP   = 3'd4
    } pc_sel_e;

    function automatic logic is_misaligned(input logic [WORD_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_stage_pc_next_mux.sv
// Combinational next-PC selection: jump > branch > stall hold > sequential,
// with the sequential path wrapping to RESET_PC past the last legal word.
module pc_next_mux
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 1000
) (
    input  logic [WORD_W-1:0] pc,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target,
    input  logic              jump,
    input  logic [WORD_W-1:0] jump_target,
    output logic [WORD_W-1:0] pc_plus4,
    output logic [WORD_W-1:0] next_pc,
    output pc_sel_e           sel
);

    localparam logic [WORD_W-1:0] LAST_ADDR = WORD_W'(IMEM_BYTES - 4);

    assign pc_plus4 = pc + PC_STEP;

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        sel     = SEL_SEQ;
        next_pc = pc_plus4;
        if (jump) begin
            sel     = SEL_JUMP;
            next_pc = jump_target;
        end else if (branch_taken) begin
            sel     = SEL_BRANCH;
            next_pc = branch_target;
        end else if (stall) begin
            sel     = SEL_HOLD;
            next_pc = pc;
        end else if (pc_plus4 > LAST_ADDR) begin
            sel     = SEL_WRAP;
            next_pc = RESET_PC;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, IF/ID pipeline register and retired-fetch counter.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (sticky trap on misaligned redirect targets).
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target,
    input  logic              jump,
    input  logic [WORD_W-1:0] jump_target,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_instr,
    output logic [WORD_W-1:0] if_id_instr,
    output logic [WORD_W-1:0] if_id_pc4,
    output logic              if_id_valid,
    output logic [WORD_W-1:0] fetch_count
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic              misalign_trap
`endif
);

    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] pc4_q, pc4_d;
    logic              valid_q, valid_d;
    logic [WORD_W-1:0] count_q, count_d;

    logic [WORD_W-1:0] mux_next_pc;
    logic [WORD_W-1:0] pc_plus4;
    pc_sel_e           pc_sel;
    logic              redirect;
    logic              freeze;
    logic              trap_active;

    pc_next_mux #(
        .RESET_PC  (RESET_PC),
        .IMEM_BYTES(IMEM_BYTES)
    ) u_pc_next_mux (
        .pc           (pc_q),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .pc_plus4     (pc_plus4),
        .next_pc      (mux_next_pc),
        .sel          (pc_sel)
    );

    assign redirect = (pc_sel == SEL_JUMP) || (pc_sel == SEL_BRANCH);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic trap_q, trap_d;
    logic trap_hit;

    // On a redirect the mux output is the winning target, so it is the address to vet.
    assign trap_hit    = redirect && is_misaligned(mux_next_pc);
    assign trap_d      = trap_q | trap_hit;
    assign freeze      = trap_q | trap_hit;
    assign trap_active = trap_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= trap_d;
        end
    end

    assign misalign_trap = trap_q;
`else
    assign freeze      = 1'b0;
    assign trap_active = 1'b0;
`endif

    always_comb begin
        pc_d    = freeze ? pc_q : mux_next_pc;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (trap_active) begin
            valid_d = 1'b0;
        end else if (flush || redirect) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!stall) begin
            instr_d = imem_instr;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
        end
        // Only a fresh capture counts; a held valid entry is not re-counted.
        count_d = count_q + ((valid_d && !(stall && !redirect && !flush) && !trap_active)
                             ? 32'd1 : 32'd0);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: sequential fetch, stall, redirects,
// flush, wrap-around (IMEM_BYTES=16 instance), async reset and the optional misalign trap.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        reset_s;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;

    logic [31:0] imem_addr, imem_instr, if_id_instr, if_id_pc4, fetch_count;
    logic        if_id_valid;
    logic [31:0] s_addr, s_instr_in, s_if_instr, s_pc4, s_count;
    logic        s_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_trap;
    logic        s_trap;
`endif

    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    assign imem_instr = mem[imem_addr[9:2]];
    assign s_instr_in = mem[s_addr[9:2]];

    fetch_stage #(.RESET_PC(32'h0), .IMEM_BYTES(1000)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .fetch_count  (fetch_count)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_trap(misalign_trap)
`endif
    );

    fetch_stage #(.RESET_PC(32'h0), .IMEM_BYTES(16)) u_small (
        .clk          (clk),
        .reset        (reset_s),
        .stall        (stall),
        .flush        (flush),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .imem_addr    (s_addr),
        .imem_instr   (s_instr_in),
        .if_id_instr  (s_if_instr),
        .if_id_pc4    (s_pc4),
        .if_id_valid  (s_valid),
        .fetch_count  (s_count)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_trap(s_trap)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                              input logic [31:0] pc4, input logic valid, input logic [31:0] cnt);
        check({tag, ".addr"},  imem_addr,           addr);
        check({tag, ".instr"}, if_id_instr,         instr);
        check({tag, ".pc4"},   if_id_pc4,           pc4);
        check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
        check({tag, ".count"}, fetch_count,         cnt);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'h2008_0005;
        mem[1] = 32'h2009_0003;
        mem[2] = 32'h0109_5020;
        mem[3] = 32'hAC0A_0000;

        reset = 1'b1; reset_s = 1'b1;
        stall = 1'b0; flush = 1'b0;
        branch_taken = 1'b0; branch_target = '0;
        jump = 1'b0; jump_target = '0;

        #2;
        check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("post_reset.addr", imem_addr, 32'h0);

        // sequential fetch
        tick(); check_ifid("seq1", 32'h4, 32'h2008_0005, 32'h4, 1'b1, 32'd1);
        tick(); check_ifid("seq2", 32'h8, 32'h2009_0003, 32'h8, 1'b1, 32'd2);

        // stall two cycles at pc=8
        stall = 1'b1;
        tick(); check_ifid("stall1", 32'h8, 32'h2009_0003, 32'h8, 1'b1, 32'd2);
        tick(); check_ifid("stall2", 32'h8, 32'h2009_0003, 32'h8, 1'b1, 32'd2);
        stall = 1'b0;
        tick(); check_ifid("resume", 32'hC, 32'h0109_5020, 32'hC, 1'b1, 32'd3);
        tick(); check_ifid("seq_to_10", 32'h10, 32'hAC0A_0000, 32'h10, 1'b1, 32'd4);

        // branch overrides stall
        branch_taken = 1'b1; branch_target = 32'h40; stall = 1'b1;
        tick(); check_ifid("branch", 32'h40, 32'h0, 32'h10, 1'b0, 32'd4);
        branch_taken = 1'b0; stall = 1'b0;
        tick(); check_ifid("after_branch", 32'h44, 32'h1000_0010, 32'h44, 1'b1, 32'd5);

        // jump beats branch
        jump = 1'b1; jump_target = 32'h80; branch_taken = 1'b1; branch_target = 32'h40;
        tick(); check_ifid("jump_vs_branch", 32'h80, 32'h0, 32'h44, 1'b0, 32'd5);
        jump = 1'b0; branch_taken = 1'b0;
        tick(); check_ifid("after_jump", 32'h84, 32'h1000_0020, 32'h84, 1'b1, 32'd6);

        // flush with stall: IF/ID invalidated, PC holds
        flush = 1'b1; stall = 1'b1;
        tick(); check_ifid("flush_stall", 32'h84, 32'h0, 32'h84, 1'b0, 32'd6);
        flush = 1'b0; stall = 1'b0;
        tick(); check_ifid("after_flush", 32'h88, 32'h1000_0021, 32'h88, 1'b1, 32'd7);

        // last legal word (996) wraps to RESET_PC; pc4 keeps the raw sum
        jump = 1'b1; jump_target = 32'd996;
        tick(); check_ifid("jump_last", 32'd996, 32'h0, 32'h88, 1'b0, 32'd7);
        jump = 1'b0;
        tick(); check_ifid("wrap_1000", 32'h0, 32'h1000_00F9, 32'd1000, 1'b1, 32'd8);

        // misaligned jump target
        jump = 1'b1; jump_target = 32'h42;
`ifdef FETCH_MISALIGN_TRAP_EN
        tick(); check_ifid("mis_jump", 32'h0, 32'h0, 32'd1000, 1'b0, 32'd8);
        check("mis_trap_set", {31'd0, misalign_trap}, 32'd1);
        jump = 1'b0;
        tick(); check_ifid("mis_frozen", 32'h0, 32'h0, 32'd1000, 1'b0, 32'd8);
        check("mis_trap_sticky", {31'd0, misalign_trap}, 32'd1);
`else
        tick(); check_ifid("mis_jump", 32'h42, 32'h0, 32'd1000, 1'b0, 32'd8);
        jump = 1'b0;
        tick(); check_ifid("mis_after", 32'h46, 32'h1000_0010, 32'h46, 1'b1, 32'd9);
`endif

        // asynchronous reset mid-cycle
        #2 reset = 1'b1;
        #1;
        check_ifid("async_reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("async_reset.trap", {31'd0, misalign_trap}, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // IMEM_BYTES=16 instance: 0,4,8,12,0
        reset_s = 1'b0;
        check("small.addr0", s_addr, 32'h0);
        tick(); check("small.addr4", s_addr, 32'h4);
        tick(); check("small.addr8", s_addr, 32'h8);
        tick(); check("small.addr12", s_addr, 32'hC);
        tick(); check("small.wrap", s_addr, 32'h0);
        check("small.pc4", s_pc4, 32'd16);
        check("small.instr", s_if_instr, 32'hAC0A_0000);
        check("small.count", s_count, 32'd4);
        #2 reset_s = 1'b1;
        #1;
        check("small.rst_pc4", s_pc4, 32'h0);
        check("small.rst_instr", s_if_instr, 32'h0);
        check("small.rst_valid", {31'd0, s_valid}, 32'd0);
        check("small.rst_count", s_count, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
